// File: rtl/psum_wb_pkg.sv
// Shared types for the psum writeback path: controller states, default widths
// and the row-FIFO entry layout {addr, data}.
package psum_wb_pkg;

  localparam int DEF_PSUM_W = 48;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN,
    DONE
  } wb_state_e;

  // Default-width entry layout; the top rebuilds the same layout from its own parameters.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_PSUM_W-1:0] data;
  } psum_entry_t;

  // The output register can take a new write when it is empty or its current write is accepted.
  function automatic logic outFree(input logic we, input logic ready);
    return !we || ready;
  endfunction

endpackage

// File: rtl/psum_row_fifo.sv
// Per-row synchronous FIFO. A push into a full FIFO only succeeds when a pop
// frees a slot in the same cycle; the owner decides what a refused push means.
module psum_row_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] popData_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic             doPush;
  logic             doPop;

  assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign doPop     = pop_i && !empty_o;
  assign doPush    = push_i && (!full_o || doPop);
  assign popData_o = mem[rdPtr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/psum_writeback.sv
// Buffers per-row psum stores in small FIFOs and serialises them onto the single
// BRAM write port through a round-robin arbiter with valid/ready backpressure.
module psum_writeback
  import psum_wb_pkg::*;
#(
  parameter int ARRAY_ROWS = 3,
  parameter int PSUM_W     = DEF_PSUM_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ARRAY_ROWS-1:0]            psum_valid_i,
  input  logic [ARRAY_ROWS-1:0][ADDR_W-1:0] psum_addr_i,
  input  logic [ARRAY_ROWS-1:0][PSUM_W-1:0] psum_data_i,
  input  logic                             flush_i,
  output logic                             bram_we_o,
  output logic [ADDR_W-1:0]                bram_addr_o,
  output logic [PSUM_W-1:0]                bram_wdata_o,
  input  logic                             bram_ready_i,
  output logic                             busy_o,
  output logic                             drained_o,
  output logic                             overflow_o
);

  localparam int ROW_W = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PSUM_W-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [ARRAY_ROWS-1:0] fifoEmpty;
  logic [ARRAY_ROWS-1:0] fifoFull;
  logic [ARRAY_ROWS-1:0] fifoPop;
  logic [ARRAY_ROWS-1:0] fifoDrop;
  logic [ENTRY_W-1:0]    fifoHead [ARRAY_ROWS];

  logic              outputFree;
  logic              grantValid;
  logic [ROW_W-1:0]  grantRow;
  entry_t            grantEntry;

  logic              bramWe_q;
  logic [ADDR_W-1:0] bramAddr_q;
  logic [PSUM_W-1:0] bramWdata_q;
  logic [ROW_W-1:0]  rrPtr_q;
  logic              overflow_q;
  logic              drained_q;
  wb_state_e         state_q;

  assign outputFree = outFree(bramWe_q, bram_ready_i);

  for (genvar r = 0; r < ARRAY_ROWS; r++) begin : gRow
    psum_row_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(ENTRY_W)
    ) uFifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (psum_valid_i[r]),
      .pushData_i({psum_addr_i[r], psum_data_i[r]}),
      .pop_i     (fifoPop[r]),
      .popData_o (fifoHead[r]),
      .full_o    (fifoFull[r]),
      .empty_o   (fifoEmpty[r])
    );

    assign fifoPop[r]  = outputFree && grantValid && (grantRow == ROW_W'(r));
    assign fifoDrop[r] = psum_valid_i[r] && fifoFull[r] && !fifoPop[r];
  end

  // Search starts one past the last granted row so every row gets a turn.
  always_comb begin
    int cand;
    cand       = 0;
    grantValid = 1'b0;
    grantRow   = rrPtr_q;
    for (int i = 1; i <= ARRAY_ROWS; i++) begin
      cand = int'(rrPtr_q) + i;
      if (cand >= ARRAY_ROWS) cand = cand - ARRAY_ROWS;
      if (!grantValid && !fifoEmpty[ROW_W'(cand)]) begin
        grantValid = 1'b1;
        grantRow   = ROW_W'(cand);
      end
    end
  end

  assign grantEntry = entry_t'(fifoHead[grantRow]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bramWe_q    <= 1'b0;
      bramAddr_q  <= '0;
      bramWdata_q <= '0;
      rrPtr_q     <= ROW_W'(ARRAY_ROWS - 1);
      overflow_q  <= 1'b0;
    end else begin
      if (outputFree) begin
        bramWe_q <= grantValid;
        if (grantValid) begin
          bramAddr_q  <= grantEntry.addr;
          bramWdata_q <= grantEntry.data;
          rrPtr_q     <= grantRow;
        end
      end
      if (|fifoDrop) overflow_q <= 1'b1;
    end
  end

  // Drain completes once nothing is buffered and the last write has been taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      drained_q <= 1'b0;
    end else begin
      drained_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (flush_i)            state_q <= DRAIN;
          else if (|psum_valid_i) state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (flush_i) state_q <= DRAIN;
        end
        DRAIN: begin
          if (&fifoEmpty && outputFree) begin
            state_q   <= DONE;
            drained_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bram_we_o    = bramWe_q;
  assign bram_addr_o  = bramAddr_q;
  assign bram_wdata_o = bramWdata_q;
  assign busy_o       = !(&fifoEmpty) || bramWe_q;
  assign drained_o    = drained_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_psum_writeback.sv
// Bench for psum_writeback: a vector table for single writes, directed sequences
// for contention, backpressure, flush and reset, with BRAM writes scoreboarded.
module tb_psum_writeback;

  localparam int ROWS  = 3;
  localparam int PW    = 48;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [ROWS-1:0]          psumValid = '0;
  logic [ROWS-1:0][AW-1:0]  psumAddr = '0;
  logic [ROWS-1:0][PW-1:0]  psumData = '0;
  logic                     flush = 1'b0;
  logic                     bramWe;
  logic [AW-1:0]            bramAddr;
  logic [PW-1:0]            bramWdata;
  logic                     bramReady = 1'b1;
  logic                     busy;
  logic                     drained;
  logic                     overflow;

  typedef struct {
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]    row;
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
    bit            expWe1;
    bit            expWe2;
    bit            expBusy3;
  } vec_t;

  exp_t sbQ[$];
  vec_t vecs[4];
  int   checks = 0;
  int   fails  = 0;

  psum_writeback #(
    .ARRAY_ROWS(ROWS),
    .PSUM_W    (PW),
    .ADDR_W    (AW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .psum_valid_i(psumValid),
    .psum_addr_i (psumAddr),
    .psum_data_i (psumData),
    .flush_i     (flush),
    .bram_we_o   (bramWe),
    .bram_addr_o (bramAddr),
    .bram_wdata_o(bramWdata),
    .bram_ready_i(bramReady),
    .busy_o      (busy),
    .drained_o   (drained),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] row, input logic [AW-1:0] a,
                               input logic [PW-1:0] d, input bit expectWrite);
    psumValid[row] = 1'b1;
    psumAddr[row]  = a;
    psumData[row]  = d;
    if (expectWrite) sbQ.push_back(exp_t'{a, d});
  endtask

  task automatic clearInputs();
    psumValid = '0;
    flush     = 1'b0;
  endtask

  task automatic waitQueueEmpty(input string name, input int budget);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, 64'(sbQ.size()), 64'd0);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sbQ.delete();
  endtask

  // Every accepted BRAM write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bramWe && bramReady) begin
      if (sbQ.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpectedWrite: got addr 0x%0h, expected no write", bramAddr);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("wrAddr", 64'(bramAddr), 64'(e.addr));
        checkOutput("wrData", 64'(bramWdata), 64'(e.data));
      end
    end
  end

  initial begin
    int staleCount;

    vecs[0] = '{2'd0, 32'h0000_0010, 48'h0000_0000_0123, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{2'd1, 32'h0000_0000, 48'h0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{2'd0, 32'h8000_0000, 48'h8000_0000_0001, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{2'd2, 32'hFFFF_FFFC, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};

    tick();
    tick();
    checkOutput("rstWe", 64'(bramWe), 64'd0);
    checkOutput("rstAddr", 64'(bramAddr), 64'd0);
    checkOutput("rstData", 64'(bramWdata), 64'd0);
    checkOutput("rstDrained", 64'(drained), 64'd0);
    checkOutput("rstOverflow", 64'(overflow), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();

    // Single uncontended writes: bram_we appears two cycles after the push.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].row, vecs[i].addr, vecs[i].data, 1'b1);
      tick();
      clearInputs();
      checkOutput("latWe1", 64'(bramWe), 64'(vecs[i].expWe1));
      tick();
      checkOutput("latWe2", 64'(bramWe), 64'(vecs[i].expWe2));
      checkOutput("latAddr", 64'(bramAddr), 64'(vecs[i].addr));
      tick();
      checkOutput("idleBusy", 64'(busy), 64'(vecs[i].expBusy3));
    end

    // Last grant was row 2, so each simultaneous burst goes out as rows 0, 1, 2.
    for (int b = 0; b < 2; b++) begin
      applyStimulus(2'd0, 32'h0000_0000, (b == 0) ? 48'hA0 : 48'hB0, 1'b1);
      applyStimulus(2'd1, 32'h0000_0100, (b == 0) ? 48'hA1 : 48'hB1, 1'b1);
      applyStimulus(2'd2, 32'h0000_0200, (b == 0) ? 48'hA2 : 48'hB2, 1'b1);
      tick();
      clearInputs();
      checkOutput("burstWe1", 64'(bramWe), 64'd0);
      for (int k = 0; k < 3; k++) begin
        tick();
        checkOutput("burstWe", 64'(bramWe), 64'd1);
        checkOutput("burstAddr", 64'(bramAddr), 64'(32'h100 * k));
      end
      tick();
      checkOutput("burstEndWe", 64'(bramWe), 64'd0);
    end
    waitQueueEmpty("burstQueue", 10);

    // Backpressure: six pushes on row 1 with the BRAM stalled; the sixth is dropped.
    bramReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'd1, 32'h1000 + i, PW'(32'hC00 + i), i < 5);
      tick();
      clearInputs();
      if (i >= 1) begin
        checkOutput("holdWe", 64'(bramWe), 64'd1);
        checkOutput("holdAddr", 64'(bramAddr), 64'h1000);
        checkOutput("holdData", 64'(bramWdata), 64'hC00);
      end
      checkOutput("ovfStep", 64'(overflow), (i == 5) ? 64'd1 : 64'd0);
    end
    tick();
    tick();
    checkOutput("holdAddrLate", 64'(bramAddr), 64'h1000);
    bramReady = 1'b1;
    waitQueueEmpty("bpQueue", 20);
    checkOutput("ovfSticky", 64'(overflow), 64'd1);

    // Full FIFO with a simultaneous pop must accept the push without overflow.
    applyReset();
    bramReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'd1, 32'h2000 + i, PW'(32'hD00 + i), 1'b1);
      tick();
      clearInputs();
    end
    bramReady = 1'b1;
    applyStimulus(2'd1, 32'h2005, 48'hD05, 1'b1);
    tick();
    clearInputs();
    checkOutput("fullPushPopOvf", 64'(overflow), 64'd0);
    waitQueueEmpty("fullQueue", 20);
    checkOutput("fullOvfEnd", 64'(overflow), 64'd0);
    tick();
    checkOutput("fullBusyEnd", 64'(busy), 64'd0);

    // Flush with three pending entries; last grant was row 1, so order is 2, 0, 1.
    applyStimulus(2'd2, 32'h3200, 48'hE2, 1'b1);
    applyStimulus(2'd0, 32'h3000, 48'hE0, 1'b1);
    applyStimulus(2'd1, 32'h3100, 48'hE1, 1'b1);
    tick();
    clearInputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      checkOutput("flushDrained", 64'(drained), (c == 5) ? 64'd1 : 64'd0);
      tick();
    end
    checkOutput("flushQueue", 64'(sbQ.size()), 64'd0);

    // Flush while idle: drained two cycles later.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("idleFlush1", 64'(drained), 64'd0);
    tick();
    checkOutput("idleFlush2", 64'(drained), 64'd1);
    tick();
    checkOutput("idleFlush3", 64'(drained), 64'd0);

    // Reset in the middle of a drain discards everything immediately.
    bramReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'd0, 32'h4000 + i, PW'(32'hF00 + i), 1'b0);
      tick();
      clearInputs();
    end
    checkOutput("preRstOvf", 64'(overflow), 64'd1);
    checkOutput("preRstWe", 64'(bramWe), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRstWe", 64'(bramWe), 64'd0);
    checkOutput("midRstBusy", 64'(busy), 64'd0);
    checkOutput("midRstOvf", 64'(overflow), 64'd0);
    checkOutput("midRstAddr", 64'(bramAddr), 64'd0);
    sbQ.delete();
    tick();
    rst = 1'b0;
    bramReady = 1'b1;
    staleCount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bramWe) staleCount++;
    end
    checkOutput("noStale", 64'(staleCount), 64'd0);

    applyStimulus(2'd2, 32'h42, 48'h99, 1'b1);
    tick();
    clearInputs();
    waitQueueEmpty("postRstQueue", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
